// File: rtl/hex_scan_if.sv
// Bus between a display source and the hex_scan sequencer:
// word/request/invalidate in, per-digit write strokes and status out.
interface hex_scan_if;
    logic [15:0] data;
    logic        req;
    logic        inval;
    logic        busy;
    logic        done;
    logic        en;
    logic [3:0]  val;
    logic [1:0]  dig;

    modport master (
        output data, req, inval,
        input  busy, done, en, val, dig
    );

    modport slave (
        input  data, req, inval,
        output busy, done, en, val, dig
    );
endinterface

// File: rtl/hex_scan.sv
// hex_scan: turns a 16-bit word into four per-digit write strokes for the
// 7-segment hex decoder, one nibble per clock. Scans start on request, on a
// periodic refresh tick, or from a coalesced pending request, and can skip
// digits whose nibble is unchanged since it was last written.
module hex_scan #(
    parameter int PERIOD       = 50000,
    parameter bit ONLY_CHANGED = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    hex_scan_if.slave bus
);

    typedef enum logic [2:0] {IDLE, SEND0, SEND1, SEND2, SEND3} state_t;

    localparam int            CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = (PERIOD > 0) ? CW'(PERIOD - 1) : '0;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          tick;
    logic          start;
    logic          pending_q;
    logic [15:0]   shadow_q;
    logic [3:0]    mask_q;
    logic [15:0]   last_q;

    logic          en_q, en_d;
    logic [3:0]    val_q, val_d;
    logic [1:0]    dig_q, dig_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [15:0]   src;
    logic [1:0]    k;
    logic [3:0]    nib;

    // Digit index carried by a SEND state (IDLE maps to 0).
    function automatic logic [1:0] dig_of(input state_t s);
        case (s)
            SEND1:   return 2'd1;
            SEND2:   return 2'd2;
            SEND3:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    assign tick  = (PERIOD != 0) && (cnt_q == CNT_LAST);
    assign start = (state_q == IDLE) && (bus.req || tick || pending_q);

    // Free-running refresh prescaler; held at 0 when refresh is disabled.
    always_ff @(posedge clk) begin
        if (rst || PERIOD == 0 || tick) cnt_q <= '0;
        else                            cnt_q <= cnt_q + CW'(1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: one digit per clock, always back through IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SEND0;
            SEND0:   state_d = SEND1;
            SEND1:   state_d = SEND2;
            SEND2:   state_d = SEND3;
            SEND3:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic for the coming cycle; digit 0 reads the live word because
    // the shadow is loaded on the same edge.
    always_comb begin
        src    = (state_q == IDLE) ? bus.data : shadow_q;
        k      = dig_of(state_d);
        nib    = src[{k, 2'b00} +: 4];
        busy_d = (state_d != IDLE);
        en_d   = busy_d && !(ONLY_CHANGED && mask_q[k] && (nib == last_q[{k, 2'b00} +: 4]));
        val_d  = busy_d ? nib : 4'd0;
        dig_d  = k;
        done_d = (state_q == SEND3);
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            val_q  <= 4'd0;
            dig_q  <= 2'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            en_q   <= en_d;
            val_q  <= val_d;
            dig_q  <= dig_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Shadow word: frozen for the whole scan so data changes cannot tear it.
    always_ff @(posedge clk) begin
        if (start) shadow_q <= bus.data;
    end

    // One-deep pending flag: requests or ticks during a scan coalesce.
    always_ff @(posedge clk) begin
        if (rst)                                        pending_q <= 1'b0;
        else if (start)                                 pending_q <= 1'b0;
        else if (state_q != IDLE && (bus.req || tick))  pending_q <= 1'b1;
    end

    // Written-digit tracking; an invalidate clears every mask bit and beats
    // any update landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= 4'b0000;
            last_q <= 16'h0000;
        end else begin
            if (en_q) last_q[{dig_q, 2'b00} +: 4] <= val_q;
            if (bus.inval)  mask_q         <= 4'b0000;
            else if (en_q)  mask_q[dig_q]  <= 1'b1;
        end
    end

    assign bus.en   = en_q;
    assign bus.val  = val_q;
    assign bus.dig  = dig_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_hex_scan.sv
// Directed bench for hex_scan: table of scans with hand-computed write
// enables, plus hand-written sequences for coalescing, reset abort and the
// periodic refresh variants.
module tb_hex_scan;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hex_scan_if b0 ();
    hex_scan_if b8 ();
    hex_scan_if bz ();

    hex_scan dut (.clk(clk), .rst(rst), .bus(b0));
    hex_scan #(.PERIOD(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    hex_scan #(.PERIOD(0)) dutz (.clk(clk), .rst(rst), .bus(bz));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] data;
        bit          inval;
        logic [3:0]  exp_en;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // One full scan on the main instance; returns at the cycle after done.
    task automatic do_scan(input logic [15:0] d, input bit inv, input logic [3:0] exp_en);
        logic [3:0] nib;
        if (inv) begin
            b0.inval = 1'b1;
            cyc();
            b0.inval = 1'b0;
        end
        b0.data = d;
        b0.req  = 1'b1;
        cyc();
        b0.req  = 1'b0;
        b0.data = ~d;
        for (int k = 0; k < 4; k++) begin
            nib = d[4*k +: 4];
            chk($sformatf("scan_en_d%0d", k), {15'd0, b0.en}, {15'd0, exp_en[k]});
            chk($sformatf("scan_busy_d%0d", k), {15'd0, b0.busy}, 16'd1);
            chk($sformatf("scan_dig_d%0d", k), {14'd0, b0.dig}, k[15:0]);
            chk($sformatf("scan_nodone_d%0d", k), {15'd0, b0.done}, 16'd0);
            if (exp_en[k]) chk($sformatf("scan_val_d%0d", k), {12'd0, b0.val}, {12'd0, nib});
            cyc();
        end
        chk("scan_done", {15'd0, b0.done}, 16'd1);
        chk("scan_done_busy", {15'd0, b0.busy}, 16'd0);
        chk("scan_done_en", {15'd0, b0.en}, 16'd0);
        cyc();
        chk("scan_done_once", {15'd0, b0.done}, 16'd0);
        cyc();
    endtask

    initial begin : main
        int dcnt, ecnt, last_done, zact;
        logic [15:0] w;

        vecs[0] = '{16'h1A2F, 1'b0, 4'b1111};
        vecs[1] = '{16'h1234, 1'b0, 4'b0111};
        vecs[2] = '{16'h1294, 1'b0, 4'b0010};
        vecs[3] = '{16'h1294, 1'b1, 4'b1111};
        vecs[4] = '{16'h1294, 1'b0, 4'b0000};
        vecs[5] = '{16'h0000, 1'b0, 4'b1111};

        rst = 1'b1;
        b0.data = 16'h0; b0.req = 1'b0; b0.inval = 1'b0;
        b8.data = 16'hC0DE; b8.req = 1'b0; b8.inval = 1'b0;
        bz.data = 16'hC0DE; bz.req = 1'b0; bz.inval = 1'b0;
        repeat (3) cyc();
        chk("rst_en", {15'd0, b0.en}, 16'd0);
        chk("rst_val", {12'd0, b0.val}, 16'd0);
        chk("rst_dig", {14'd0, b0.dig}, 16'd0);
        chk("rst_busy", {15'd0, b0.busy}, 16'd0);
        chk("rst_done", {15'd0, b0.done}, 16'd0);
        rst = 1'b0;
        cyc();

        foreach (vecs[i]) do_scan(vecs[i].data, vecs[i].inval, vecs[i].exp_en);

        // Coalesced requests: one follow-up scan that captures data at its start.
        b0.data = 16'h5555;
        b0.req  = 1'b1;
        cyc();                                   // N+1
        b0.req  = 1'b0;
        chk("coal_d0_en", {15'd0, b0.en}, 16'd1);
        chk("coal_d0_val", {12'd0, b0.val}, 16'h5);
        cyc();                                   // N+2
        b0.req = 1'b1;
        cyc();                                   // N+3
        cyc();                                   // N+4
        b0.req  = 1'b0;
        b0.data = 16'hBEEF;
        cyc();                                   // N+5
        chk("coal_done1", {15'd0, b0.done}, 16'd1);
        chk("coal_done1_en", {15'd0, b0.en}, 16'd0);
        w = 16'hBEEF;
        for (int k = 0; k < 4; k++) begin
            cyc();                               // N+6..N+9
            chk($sformatf("coal_en_d%0d", k), {15'd0, b0.en}, 16'd1);
            chk($sformatf("coal_dig_d%0d", k), {14'd0, b0.dig}, k[15:0]);
            chk($sformatf("coal_val_d%0d", k), {12'd0, b0.val}, {12'd0, w[4*k +: 4]});
        end
        cyc();                                   // N+10
        chk("coal_done2", {15'd0, b0.done}, 16'd1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("coal_no_third", {14'd0, b0.busy, b0.done}, 16'd0);
        end

        // Reset during SEND(2) aborts the scan and clears the mask.
        b0.data = 16'h1234;
        b0.req  = 1'b1;
        cyc();                                   // SEND(0)
        b0.req = 1'b0;
        cyc();                                   // SEND(1)
        cyc();                                   // SEND(2)
        chk("abort_in_send2", {14'd0, b0.dig}, 16'd2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort_en", {15'd0, b0.en}, 16'd0);
        chk("abort_busy", {15'd0, b0.busy}, 16'd0);
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_done", {15'd0, b0.done}, 16'd0);
            cyc();
        end
        do_scan(16'h1234, 1'b0, 4'b1111);

        // Periodic refresh: fresh reset, then watch PERIOD=8 and PERIOD=0.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        dcnt = 0; ecnt = 0; last_done = -1; zact = 0;
        for (int c = 0; c < 80; c++) begin
            cyc();
            if (b8.en) ecnt++;
            if (b8.done) begin
                dcnt++;
                if (last_done >= 0) chk("p8_interval", 16'(c - last_done), 16'd8);
                last_done = c;
            end
            if (bz.en || bz.busy || bz.done) zact++;
        end
        chk("p8_scans_ge9", {15'd0, (dcnt >= 9)}, 16'd1);
        chk("p8_en_first_only", 16'(ecnt), 16'd4);
        chk("p0_no_activity", 16'(zact), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
